// File: rtl/cpu_run_ctrl_if.sv
// Host command channel for cpu_run_ctrl: valid/ready handshake carrying an op code and run length.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;

    modport master (output cmd_valid, output cmd_op, output cmd_count, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_count, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: gates the core clock enable for halt / step / run-N / run-free host commands.
// Optional PC breakpoint stop is compiled in with CPU_RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int unsigned CNT_W = 16,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    parameter int unsigned PC_W  = 32,
`endif
    parameter int unsigned TOT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    cpu_run_ctrl_if.slave    cmd,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
`endif
    output logic             cpu_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       halt_cause,
    output logic [TOT_W-1:0] cycle_cnt
);

    typedef enum logic {S_IDLE, S_RUN} state_e;
    typedef enum logic [1:0] {CAUSE_NONE, CAUSE_COUNT, CAUSE_HOST, CAUSE_BREAK} cause_e;

    localparam logic [1:0] OP_HALT     = 2'b00;
    localparam logic [1:0] OP_STEP     = 2'b01;
    localparam logic [1:0] OP_RUN_N    = 2'b10;
    localparam logic [1:0] OP_RUN_FREE = 2'b11;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               free_q, free_d;
    logic               en_q, en_d;
    logic               done_q, done_d;
    cause_e             cause_q, cause_d;
    logic [TOT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic               stop_count, stop_host, stop_bp;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic               first_q, first_d;
`endif

    assign cmd.cmd_ready = 1'b1;

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        free_d      = free_q;
        done_d      = 1'b0;
        cause_d     = cause_q;
        cycle_cnt_d = cycle_cnt_q + TOT_W'(en_q);
        stop_count  = 1'b0;
        stop_host   = 1'b0;
        stop_bp     = 1'b0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        // Only the first enabled cycle after IDLE sees first_q set, so a resume steps off a breakpoint.
        first_d     = (state_q == S_IDLE);
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    case (cmd.cmd_op)
                        OP_STEP: begin
                            state_d     = S_RUN;
                            remaining_d = CNT_W'(1);
                            free_d      = 1'b0;
                        end
                        OP_RUN_N: begin
                            if (cmd.cmd_count != '0) begin
                                state_d     = S_RUN;
                                remaining_d = CNT_W'(cmd.cmd_count);
                                free_d      = 1'b0;
                            end else begin
                                done_d  = 1'b1;
                                cause_d = CAUSE_COUNT;
                            end
                        end
                        OP_RUN_FREE: begin
                            state_d = S_RUN;
                            free_d  = 1'b1;
                        end
                        default: begin
                            done_d  = 1'b1;
                            cause_d = CAUSE_HOST;
                        end
                    endcase
                end
            end
            S_RUN: begin
                stop_count = !free_q && (remaining_q == CNT_W'(1));
                stop_host  = cmd.cmd_valid && (cmd.cmd_op == OP_HALT);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                stop_bp    = bp_valid && (pc == bp_addr) && !first_q;
`endif
                if (!free_q && (remaining_q != '0)) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
                if (stop_bp || stop_host || stop_count) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    remaining_d = '0;
                    free_d      = 1'b0;
                    if (stop_bp)        cause_d = CAUSE_BREAK;
                    else if (stop_host) cause_d = CAUSE_HOST;
                    else                cause_d = CAUSE_COUNT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            free_q      <= 1'b0;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
            cause_q     <= CAUSE_NONE;
            cycle_cnt_q <= '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            free_q      <= free_d;
            en_q        <= en_d;
            done_q      <= done_d;
            cause_q     <= cause_d;
            cycle_cnt_q <= cycle_cnt_d;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            first_q     <= first_d;
`endif
        end
    end

    assign cpu_en     = en_q;
    assign busy       = en_q;
    assign done       = done_q;
    assign halt_cause = cause_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: vector table, directed corner sequences, randomized run vs. reference model.
module tb_cpu_run_ctrl;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TOT_W = 32;
    localparam logic [1:0] OP_HALT = 2'd0, OP_STEP = 2'd1, OP_RUNN = 2'd2, OP_FREE = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.CNT_W(CNT_W)) bus ();
    logic             cpu_en, busy, done;
    logic [1:0]       halt_cause;
    logic [TOT_W-1:0] cycle_cnt;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic [31:0] pc, bp_addr;
    logic        bp_valid;
`endif

    cpu_run_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (bus),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_valid  (bp_valid),
`endif
        .cpu_en    (cpu_en),
        .busy      (busy),
        .done      (done),
        .halt_cause(halt_cause),
        .cycle_cnt (cycle_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] n);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_count = n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, OP_HALT, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic             v;
        logic [1:0]       op;
        logic [CNT_W-1:0] n;
        logic             en;
        logic             dn;
        logic [1:0]       cause;
        int unsigned      cnt;
    } vec_t;

    vec_t tbl[18];

    // Reference model state: run window expressed as absolute cycle numbers
    bit          m_act, m_done;
    int          m_start, m_last;
    logic [1:0]  m_cause;
    logic [31:0] m_cnt;

    initial begin
        int en_seen, dn_seen, dn_at;
        // inputs in cycle r -> outputs observed in cycle r+1
        tbl[0]  = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b0, 2'd0, 0};
        tbl[1]  = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b0, 2'd0, 0};
        tbl[2]  = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b0, 2'd0, 0};
        tbl[3]  = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b0, 2'd0, 0};
        tbl[4]  = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b0, 2'd0, 0};
        tbl[5]  = '{1'b1, OP_STEP, 16'd0, 1'b1, 1'b0, 2'd0, 0};
        tbl[6]  = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b1, 2'd1, 1};
        tbl[7]  = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b0, 2'd1, 1};
        tbl[8]  = '{1'b1, OP_RUNN, 16'd0, 1'b0, 1'b1, 2'd1, 1};
        tbl[9]  = '{1'b1, OP_HALT, 16'd0, 1'b0, 1'b1, 2'd2, 1};
        tbl[10] = '{1'b1, OP_RUNN, 16'd2, 1'b1, 1'b0, 2'd2, 1};
        tbl[11] = '{1'b1, OP_STEP, 16'd0, 1'b1, 1'b0, 2'd2, 2};
        tbl[12] = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b1, 2'd1, 3};
        tbl[13] = '{1'b1, OP_RUNN, 16'd3, 1'b1, 1'b0, 2'd1, 3};
        tbl[14] = '{1'b0, OP_HALT, 16'd0, 1'b1, 1'b0, 2'd1, 4};
        tbl[15] = '{1'b0, OP_HALT, 16'd0, 1'b1, 1'b0, 2'd1, 5};
        tbl[16] = '{1'b1, OP_HALT, 16'd0, 1'b0, 1'b1, 2'd2, 6};
        tbl[17] = '{1'b0, OP_HALT, 16'd0, 1'b0, 1'b0, 2'd2, 6};

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        pc = 32'h0; bp_addr = 32'h40; bp_valid = 1'b0;
`endif
        do_reset();
        chk("reset_en", 64'(cpu_en), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_cause", 64'(halt_cause), 64'd0);
        chk("reset_cnt", 64'(cycle_cnt), 64'd0);
        chk("cmd_ready", 64'(bus.cmd_ready), 64'd1);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].n);
            tick();
            chk($sformatf("vec%0d_en", i), 64'(cpu_en), 64'(tbl[i].en));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].en));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(tbl[i].dn));
            chk($sformatf("vec%0d_cause", i), 64'(halt_cause), 64'(tbl[i].cause));
            chk($sformatf("vec%0d_cnt", i), 64'(cycle_cnt), 64'(tbl[i].cnt));
        end

        // RUN_N 10: exactly ten enables, then a single done
        drive(1'b1, OP_RUNN, 16'd10);
        en_seen = 0; dn_seen = 0; dn_at = -1;
        for (int k = 0; k < 14; k++) begin
            tick();
            drive(1'b0, OP_HALT, '0);
            if (cpu_en) en_seen++;
            if (done) begin dn_seen++; dn_at = k; chk("run10_done_en_low", 64'(cpu_en), 64'd0); end
        end
        chk("run10_en_cycles", 64'(en_seen), 64'd10);
        chk("run10_done_count", 64'(dn_seen), 64'd1);
        chk("run10_done_pos", 64'(dn_at), 64'd10);
        chk("run10_cause", 64'(halt_cause), 64'd1);
        chk("run10_cnt", 64'(cycle_cnt), 64'd16);

        // RUN_N 0: no enable, done next cycle with COUNT
        drive(1'b1, OP_RUNN, 16'd0);
        tick();
        drive(1'b0, OP_HALT, '0);
        chk("run0_en", 64'(cpu_en), 64'd0);
        chk("run0_done", 64'(done), 64'd1);
        chk("run0_cause", 64'(halt_cause), 64'd1);

        // RUN_FREE, stray STEP mid-run, HALT 20 cycles after first enable
        drive(1'b1, OP_FREE, '0);
        tick();
        en_seen = int'(cpu_en);
        for (int k = 1; k <= 20; k++) begin
            drive(k == 7, OP_STEP, 16'd3);
            tick();
            if (cpu_en) en_seen++;
        end
        drive(1'b1, OP_HALT, '0);
        tick();
        drive(1'b0, OP_HALT, '0);
        chk("free_en_cycles", 64'(en_seen), 64'd21);
        chk("free_halt_en", 64'(cpu_en), 64'd0);
        chk("free_halt_done", 64'(done), 64'd1);
        chk("free_halt_cause", 64'(halt_cause), 64'd2);
        chk("free_cnt", 64'(cycle_cnt), 64'd37);

        // RUN_N 5 with HALT in the last enabled cycle: HOST wins over COUNT
        drive(1'b1, OP_RUNN, 16'd5);
        tick();
        drive(1'b0, OP_HALT, '0);
        for (int k = 0; k < 4; k++) tick();
        chk("run5_en_5th", 64'(cpu_en), 64'd1);
        drive(1'b1, OP_HALT, '0);
        tick();
        drive(1'b0, OP_HALT, '0);
        chk("run5_halt_en", 64'(cpu_en), 64'd0);
        chk("run5_halt_done", 64'(done), 64'd1);
        chk("run5_halt_cause", 64'(halt_cause), 64'd2);
        chk("run5_cnt", 64'(cycle_cnt), 64'd42);
        tick();
        chk("run5_done_pulse", 64'(done), 64'd0);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        // Breakpoint on 3rd enabled cycle, then resume steps off it
        bp_addr = 32'h40; bp_valid = 1'b1; pc = 32'h10;
        drive(1'b1, OP_FREE, '0);
        tick();
        drive(1'b0, OP_HALT, '0);
        tick();
        tick();
        pc = 32'h40;
        chk("bp_en_3rd", 64'(cpu_en), 64'd1);
        tick();
        chk("bp_stop_en", 64'(cpu_en), 64'd0);
        chk("bp_stop_done", 64'(done), 64'd1);
        chk("bp_stop_cause", 64'(halt_cause), 64'd3);
        drive(1'b1, OP_FREE, '0);
        tick();
        drive(1'b0, OP_HALT, '0);
        chk("bp_resume_en1", 64'(cpu_en), 64'd1);
        tick();
        chk("bp_resume_en2", 64'(cpu_en), 64'd1);
        chk("bp_resume_nodone", 64'(done), 64'd0);
        pc = 32'h44;
        drive(1'b1, OP_HALT, '0);
        tick();
        drive(1'b0, OP_HALT, '0);
        chk("bp_resume_halt_cause", 64'(halt_cause), 64'd2);
        bp_valid = 1'b0; pc = 32'h0;
`endif

        // Reset in the 4th enabled cycle of RUN_N 100
        drive(1'b1, OP_RUNN, 16'd100);
        tick();
        drive(1'b0, OP_HALT, '0);
        tick(); tick(); tick();
        chk("rst_pre_en", 64'(cpu_en), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_en", 64'(cpu_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cnt", 64'(cycle_cnt), 64'd0);
        chk("rst_cause", 64'(halt_cause), 64'd0);
        drive(1'b1, OP_STEP, '0);
        tick();
        drive(1'b0, OP_HALT, '0);
        chk("rst_step_en", 64'(cpu_en), 64'd1);
        tick();
        chk("rst_step_done", 64'(done), 64'd1);
        chk("rst_step_cause", 64'(halt_cause), 64'd1);
        chk("rst_step_cnt", 64'(cycle_cnt), 64'd1);

        // Randomized run against the reference model
        do_reset();
        m_act = 0; m_done = 0; m_start = -1; m_last = -1; m_cause = 2'd0; m_cnt = '0;
        for (int c = 0; c < 3000; c++) begin
            logic v;
            logic [1:0] op;
            logic [CNT_W-1:0] n;
            bit sc, sh, sb, n_act, n_done;
            v  = ($urandom % 4) == 0;
            op = 2'($urandom % 4);
            n  = CNT_W'($urandom % 8);
            drive(v, op, n);
            sb = 0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            pc       = 32'h40 + 32'(4 * ($urandom % 3));
            bp_valid = 1'($urandom % 2);
            sb = m_act && bp_valid && (pc == bp_addr) && (c != m_start);
`endif
            n_act = m_act;
            n_done = 0;
            if (m_act) begin
                sc = (m_last >= 0) && (c == m_last);
                sh = v && (op == OP_HALT);
                if (sb || sh || sc) begin
                    n_act = 0;
                    n_done = 1;
                    m_cause = sb ? 2'd3 : (sh ? 2'd2 : 2'd1);
                end
            end else if (v) begin
                case (op)
                    OP_STEP: begin n_act = 1; m_start = c + 1; m_last = c + 1; end
                    OP_RUNN: begin
                        if (n == 0) begin n_done = 1; m_cause = 2'd1; end
                        else begin n_act = 1; m_start = c + 1; m_last = c + int'(n); end
                    end
                    OP_FREE: begin n_act = 1; m_start = c + 1; m_last = -1; end
                    default: begin n_done = 1; m_cause = 2'd2; end
                endcase
            end
            if (m_act) m_cnt = m_cnt + 32'd1;
            m_act = n_act;
            m_done = n_done;
            tick();
            chk("rnd_en", 64'(cpu_en), 64'(m_act));
            chk("rnd_busy", 64'(busy), 64'(m_act));
            chk("rnd_done", 64'(done), 64'(m_done));
            chk("rnd_cause", 64'(halt_cause), 64'(m_cause));
            chk("rnd_cnt", 64'(cycle_cnt), 64'(m_cnt));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller that drives the CPU core's clock enable for directed simulation and on-board debug. It executes host commands: halt, single-step, run N cycles, or run free. Every enabled cycle is counted, and completion is reported with a cause code. It sits between the CPU top level and the testbench/debug host, which no longer toggles the core clock by hand.

## Interface
- `CNT_W`, 16 — width of the run-length counter (`cmd_count`).
- `PC_W`, 32 — width of the program counter compared for breakpoints.
- `TOT_W`, 32 — width of the total enabled-cycle counter.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  controller accepts a command this cycle.
- `cmd_op`  in  2  operation: 00 HALT, 01 STEP, 10 RUN_N, 11 RUN_FREE.
- `cmd_count`  in  CNT_W  cycle count for RUN_N; ignored for other ops.
- `pc`  in  PC_W  current CPU program counter (breakpoint build only).
- `bp_addr`  in  PC_W  breakpoint address (breakpoint build only).
- `bp_valid`  in  1  breakpoint armed (breakpoint build only).
- `cpu_en`  out  1  registered clock enable to the CPU core.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a run ends.
- `halt_cause`  out  2  00 none, 01 COUNT, 10 HOST, 11 BREAK; held until the next `done`.
- `cycle_cnt`  out  TOT_W  total `cpu_en`-high cycles since reset; wraps modulo 2^TOT_W.

## Operation
- States: IDLE, RUN. `cpu_en` = `busy` = (state == RUN), both registered.
- `cmd_ready` is tied to 1. A command is accepted on `cmd_valid && cmd_ready`.
- Commands accepted in IDLE:
  - STEP: enter RUN with remaining = 1.
  - RUN_N with N > 0: enter RUN with remaining = N.
  - RUN_N with N = 0: stay in IDLE, pulse `done` next cycle, cause COUNT.
  - RUN_FREE: enter RUN in free mode; no count limit.
  - HALT: stay in IDLE, pulse `done` next cycle, cause HOST.
- Commands accepted in RUN:
  - HALT: request a stop.
  - STEP, RUN_N, RUN_FREE: accepted and discarded. No state change.
- In RUN, each cycle decrements remaining unless in free mode. The run ends after the cycle where remaining == 1, on an accepted HALT, or on a breakpoint hit.
- At run end: return to IDLE, pulse `done`, update `halt_cause`.
- If several stop conditions occur in the same cycle, cause priority is BREAK > HOST > COUNT.
- `cycle_cnt` increments on every cycle with `cpu_en` = 1.

## Timing
- Reset values: state IDLE; `cpu_en`, `busy`, `done` = 0; `halt_cause` = 00; `cycle_cnt` = 0; remaining = 0.
- Latency: command accepted in cycle t → `cpu_en` high from t+1.
- RUN_N: `cpu_en` is high for exactly N consecutive cycles, t+1 through t+N. `done` is high at t+N+1, with `cpu_en` low.
- HALT accepted in RUN at cycle h: cycle h still counts as enabled. `cpu_en` is low from h+1 and `done` is high at h+1.
- Back-to-back: a command can be accepted in the same cycle `done` is high, because the state is already IDLE.
- `rst` during RUN: `cpu_en` is low on the next cycle, no `done` pulse, and all state is cleared.
- `remaining` is CNT_W bits wide and never underflows. Free mode does not decrement it.

## Configuration
- Macro: `CPU_RUN_CTRL_BREAKPOINT_EN`.
- Defined:
  - Ports `pc`, `bp_addr`, `bp_valid` are present.
  - A hit is a cycle in RUN with `cpu_en` = 1, `bp_valid` = 1 and `pc` == `bp_addr`. That cycle executes, then the run stops with cause BREAK.
  - The first enabled cycle of each run is exempt, so resuming from a breakpoint steps off it.
- Undefined:
  - Ports `pc`, `bp_addr`, `bp_valid` are absent.
  - BREAK is never reported.
  - No comparator logic is generated.

## Test plan
- Reset, then STEP at cycle 5 → `cpu_en` is high only in cycle 6. `done` is high in cycle 7 with `halt_cause` = 01. `cycle_cnt` = 1.
- RUN_N with `cmd_count` = 10 → exactly 10 enabled cycles, `done` once, `cycle_cnt` = 10. Then RUN_N 0 → no enable, `done` the next cycle, cause 01.
- RUN_FREE, then HALT 20 cycles after the first enable → 21 enabled cycles, `done` one cycle after HALT, cause 10. A STEP issued mid-run is ignored (count unchanged).
- RUN_N 5 with HALT in the 5th enabled cycle → 5 enabled cycles, cause 10 (HOST outranks COUNT).
- Breakpoint build: `bp_addr` = 0x40, `pc` reaches 0x40 in the 3rd enabled cycle of RUN_FREE → stop after that cycle, cause 11. Re-issuing RUN_FREE with `pc` still at 0x40 → it runs past the breakpoint (first-cycle exemption).
- `rst` asserted in the 4th cycle of RUN_N 100 → `cpu_en` low the next cycle, no `done`, `cycle_cnt` = 0, and a STEP is accepted right after reset.
